load_store_unit: RTL

//  CPU-side initiator for the word-wide data memory.
//  - Accepts one load/store request at a time from the MIPS datapath.
//  - Converts each request into word accesses on the memory port:

---
 rtl/load_store_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : CPU-side initiator for a word-wide data memory. Accepts one
//               load/store at a time, turns byte/half loads into word reads
//               with sign/zero extension and byte/half stores into a
//               read-modify-write of the containing word.
// Options     : MISALIGN_TRAP_EN - when defined, misaligned half/word
//               requests complete immediately with resp_err=1 and no memory
//               traffic; when undefined, the low address bits are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_READ    = 2'd1;
  localparam logic [1:0] c_WRITE   = 2'd2;
  localparam logic [1:0] c_RESP    = 2'd3;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic                  w_accept;
  logic                  w_req_sub;
  logic                  w_mis;

  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_word;
  logic [31:0]           r_rdata;

  logic [1:0]            w_off;
  logic [4:0]            w_shift;
  logic [15:0]           w_lane;
  logic [31:0]           w_load;
  logic [31:0]           w_mask;
  logic [31:0]           w_ins;
  logic [31:0]           w_merged;
  logic                  w_reg_sub;

  assign w_accept  = req_valid && req_ready;
  assign w_req_sub = (req_size == c_SZ_BYTE) || (req_size == c_SZ_HALF);
  assign w_reg_sub = (r_size == c_SZ_BYTE) || (r_size == c_SZ_HALF);

`ifdef MISALIGN_TRAP_EN
  // Half needs an even address; word (including reserved size) needs 4-byte alignment.
  assign w_mis = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (req_valid) begin
          if (w_mis) begin
            w_next = c_RESP;
          end else if (!req_write || w_req_sub) begin
            w_next = c_READ;
          end else begin
            w_next = c_WRITE;
          end
        end
      end
      c_READ:  w_next = r_write ? c_WRITE : c_RESP;
      c_WRITE: w_next = c_RESP;
      c_RESP:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Handshake and memory strobes are pure state decodes.
  always_comb begin
    req_ready  = (r_state == c_IDLE);
    mem_re     = (r_state == c_READ);
    mem_we     = (r_state == c_WRITE);
    resp_valid = (r_state == c_RESP);
  end

  // Byte offset of the addressed lane; half uses addr[1] only, word is always lane 0.
  always_comb begin
    w_off   = 2'b00;
    w_shift = 5'd0;
    case (r_size)
      c_SZ_BYTE: w_off = r_addr[1:0];
      c_SZ_HALF: w_off = {r_addr[1], 1'b0};
      default:   w_off = 2'b00;
    endcase
    if (BIG_ENDIAN != 0) begin
      // Offset 0 sits in the most significant byte.
      case (r_size)
        c_SZ_BYTE: w_shift = {~w_off, 3'b000};
        c_SZ_HALF: w_shift = {~w_off[1], 4'b0000};
        default:   w_shift = 5'd0;
      endcase
    end else begin
      case (r_size)
        c_SZ_BYTE: w_shift = {w_off, 3'b000};
        c_SZ_HALF: w_shift = {w_off[1], 4'b0000};
        default:   w_shift = 5'd0;
      endcase
    end
  end

  // Load extraction and extension straight from the memory read data.
  always_comb begin
    w_lane = 16'(mem_rdata >> w_shift);
    case (r_size)
      c_SZ_BYTE: w_load = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
      c_SZ_HALF: w_load = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default:   w_load = mem_rdata;
    endcase
  end

  // Store merge: replace only the addressed lane of the captured word.
  always_comb begin
    w_mask    = ((r_size == c_SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
    w_ins     = r_wdata << w_shift;
    w_merged  = (r_word & ~w_mask) | (w_ins & w_mask);
    mem_wdata = w_reg_sub ? w_merged : r_wdata;
  end

  assign mem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign resp_rdata = r_rdata;

  // Request capture, read-word capture and response data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_word   <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        if (w_mis) begin
          r_rdata <= 32'd0;
        end
      end
      if (r_state == c_READ) begin
        r_word <= mem_rdata;
        if (!r_write) begin
          r_rdata <= w_load;
        end
      end
      if (r_state == c_WRITE) begin
        r_rdata <= 32'd0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_err;

  // Error flag is written on every edge that produces a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_accept && w_mis) begin
      r_err <= 1'b1;
    end else if ((r_state == c_READ && !r_write) || r_state == c_WRITE) begin
      r_err <= 1'b0;
    end
  end

  assign resp_err = r_err;
`else
  assign resp_err = 1'b0;
`endif

endmodule
`default_nettype wire
